// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction-memory port arbiter: default widths,
// halt-state encoding and requester IDs.
package imem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W       = 12;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_DBG_MAX_WAIT = 8;
  localparam int unsigned DEF_CNT_W        = 4;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } halt_state_e;

  localparam logic ID_IF  = 1'b0;
  localparam logic ID_DBG = 1'b1;

  // True when the tracked memory read belongs to the fetch side.
  function automatic logic is_fetch_owner(input logic vld, input logic id);
    return vld && (id == ID_IF);
  endfunction

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating count of consecutive blocked debug-request cycles; force_dbg
// asserts once the count reaches DBG_MAX_WAIT.
module imem_starve_cnt
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned DBG_MAX_WAIT = DEF_DBG_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_dbg
);

  localparam logic [CNT_W-1:0] MaxWait = CNT_W'(DBG_MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!dbg_req || dbg_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MaxWait) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_dbg = (wait_cnt_q == MaxWait);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a single-port synchronous-read instruction memory between CPU fetch
// (priority) and the debug port, with starvation guard and a halt FSM.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned DBG_MAX_WAIT = DEF_DBG_MAX_WAIT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt,
  output logic              halted,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  halt_state_e state_q, state_d;
  logic        owner_vld_q, owner_vld_d;
  logic        owner_id_q, owner_id_d;
  logic        halted_q, halted_d;
  logic        force_dbg;
  logic        fetch_inflight;

  imem_starve_cnt #(
    .CNT_W       (CNT_W),
    .DBG_MAX_WAIT(DBG_MAX_WAIT)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .dbg_req  (dbg_req),
    .dbg_gnt  (dbg_gnt),
    .force_dbg(force_dbg)
  );

  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StRun: begin
          if (force_dbg) begin
            dbg_gnt = dbg_req;
          end else begin
            if_gnt  = if_req;
            dbg_gnt = dbg_req & ~if_req;
          end
        end
        default: dbg_gnt = dbg_req;
      endcase
    end
  end

  assign mem_en   = if_gnt | dbg_gnt;
  assign mem_addr = if_gnt ? if_addr : (dbg_gnt ? dbg_addr : '0);

  always_comb begin
    owner_vld_d = mem_en;
    owner_id_d  = dbg_gnt ? ID_DBG : ID_IF;
  end

  // A fetch granted this cycle is the read that must drain before halting.
  assign fetch_inflight = is_fetch_owner(owner_vld_d, owner_id_d);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (dbg_halt) begin
          state_d = fetch_inflight ? StDrain : StHalted;
        end
      end
      StDrain:  state_d = dbg_halt ? StHalted : StRun;
      StHalted: state_d = dbg_halt ? StHalted : StRun;
      default:  state_d = StRun;
    endcase
    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      owner_vld_q <= 1'b0;
      owner_id_q  <= ID_IF;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_vld_q <= owner_vld_d;
      owner_id_q  <= owner_id_d;
      halted_q    <= halted_d;
    end
  end

  assign if_rvalid  = owner_vld_q & (owner_id_q == ID_IF);
  assign dbg_rvalid = owner_vld_q & (owner_id_q == ID_DBG);
  assign if_rdata   = mem_rdata;
  assign dbg_rdata  = mem_rdata;
  assign halted     = halted_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed vector table, hand
// sequences for contention and reset, then random traffic against a model.
module tb_imem_port_arbiter;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dbg_req = 1'b0, dbg_halt = 1'b0;
  logic [11:0] if_addr = '0, dbg_addr = '0;
  logic        if_gnt, if_rvalid, dbg_gnt, dbg_rvalid, halted, mem_en;
  logic [31:0] if_rdata, dbg_rdata, mem_rdata;
  logic [11:0] mem_addr;

  int checks = 0;
  int failures = 0;

  imem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_gnt   (dbg_gnt),
    .dbg_rvalid(dbg_rvalid),
    .dbg_rdata (dbg_rdata),
    .dbg_halt  (dbg_halt),
    .halted    (halted),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [11:0] a);
    return {a, 4'hA, a, 4'h5} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous-read memory model.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= word(mem_addr);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending-response queue, blocked-cycle count, halt flags.
  typedef struct {
    bit          dbg;
    logic [11:0] addr;
  } rsp_t;
  rsp_t m_q[$];
  int   m_blocked;
  bit   m_frozen;
  bit   m_halted;

  function automatic void model_reset();
    m_q.delete();
    m_blocked = 0;
    m_frozen  = 0;
    m_halted  = 0;
  endfunction

  // Called at a negedge; leaves the bench at the next negedge with rst low.
  task automatic do_reset();
    rst = 1'b1; if_req = 1'b1; dbg_req = 1'b1; dbg_halt = 1'b0;
    #1;
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_dbg_rvalid", dbg_rvalid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; dbg_req = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic ir; logic [11:0] ia; logic dr; logic [11:0] da; logic hlt;
    logic eig; logic edg; logic [11:0] emaddr; logic eiv; logic edv;
    logic [11:0] eraddr; logic ehalt;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mkv(logic ir, logic [11:0] ia, logic dr, logic [11:0] da, logic hlt,
                               logic eig, logic edg, logic [11:0] emaddr, logic eiv, logic edv,
                               logic [11:0] eraddr, logic ehalt);
    vec_t v;
    v = '{ir, ia, dr, da, hlt, eig, edg, emaddr, eiv, edv, eraddr, ehalt};
    return v;
  endfunction

  task automatic random_step();
    logic e_ig, e_dg, e_iv, e_dv, frc;
    logic [11:0] e_ad;
    if ($urandom_range(0, 7) != 0) if_req = 1'b1; else if_req = 1'b0;
    if ($urandom_range(0, 5) == 0) dbg_req = ~dbg_req;
    if ($urandom_range(0, 11) == 0) dbg_halt = ~dbg_halt;
    if_addr  = 12'($urandom);
    dbg_addr = 12'($urandom);
    #1;
    frc = !m_frozen && (m_blocked == MAXW);
    if (m_frozen || frc) begin
      e_ig = 1'b0; e_dg = dbg_req;
    end else begin
      e_ig = if_req; e_dg = dbg_req && !if_req;
    end
    e_ad = e_ig ? if_addr : (e_dg ? dbg_addr : 12'h000);
    e_iv = (m_q.size() > 0) && !m_q[0].dbg;
    e_dv = (m_q.size() > 0) && m_q[0].dbg;
    chk1("rnd_if_gnt", if_gnt, e_ig);
    chk1("rnd_dbg_gnt", dbg_gnt, e_dg);
    chk1("rnd_mem_en", mem_en, e_ig || e_dg);
    chk32("rnd_mem_addr", 32'(mem_addr), 32'(e_ad));
    chk1("rnd_if_rvalid", if_rvalid, e_iv);
    chk1("rnd_dbg_rvalid", dbg_rvalid, e_dv);
    chk1("rnd_halted", halted, m_halted);
    if (e_iv) chk32("rnd_if_rdata", if_rdata, word(m_q[0].addr));
    if (e_dv) chk32("rnd_dbg_rdata", dbg_rdata, word(m_q[0].addr));
    // Advance the model to the state after the coming rising edge.
    if (m_q.size() > 0) void'(m_q.pop_front());
    if (e_ig) m_q.push_back('{1'b0, if_addr});
    else if (e_dg) m_q.push_back('{1'b1, dbg_addr});
    if (dbg_req && !e_dg) m_blocked = (m_blocked + 1 > MAXW) ? MAXW : m_blocked + 1;
    else m_blocked = 0;
    if (!dbg_halt) begin
      m_frozen = 0; m_halted = 0;
    end else if (m_frozen) begin
      m_halted = 1;
    end else begin
      m_frozen = 1; m_halted = !e_ig;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //            ir  ia       dr  da       hlt eig edg emaddr  eiv edv eraddr  ehalt
    tbl[0]  = mkv(1, 12'h000, 0, 12'h000, 0,  1,  0,  12'h000, 0,  0,  12'h000, 0);
    tbl[1]  = mkv(1, 12'h001, 0, 12'h000, 0,  1,  0,  12'h001, 1,  0,  12'h000, 0);
    tbl[2]  = mkv(1, 12'h002, 0, 12'h000, 0,  1,  0,  12'h002, 1,  0,  12'h001, 0);
    tbl[3]  = mkv(1, 12'h003, 0, 12'h000, 0,  1,  0,  12'h003, 1,  0,  12'h002, 0);
    tbl[4]  = mkv(0, 12'h000, 0, 12'h000, 0,  0,  0,  12'h000, 1,  0,  12'h003, 0);
    tbl[5]  = mkv(0, 12'h000, 0, 12'h000, 0,  0,  0,  12'h000, 0,  0,  12'h000, 0);
    tbl[6]  = mkv(1, 12'h005, 0, 12'h000, 1,  1,  0,  12'h005, 0,  0,  12'h000, 0);
    tbl[7]  = mkv(1, 12'h006, 0, 12'h000, 1,  0,  0,  12'h000, 1,  0,  12'h005, 0);
    tbl[8]  = mkv(1, 12'h007, 1, 12'h00B, 1,  0,  1,  12'h00B, 0,  0,  12'h000, 1);
    tbl[9]  = mkv(1, 12'h007, 1, 12'h00C, 1,  0,  1,  12'h00C, 0,  1,  12'h00B, 1);
    tbl[10] = mkv(1, 12'h007, 0, 12'h000, 0,  0,  0,  12'h000, 0,  1,  12'h00C, 1);
    tbl[11] = mkv(1, 12'hFFF, 0, 12'h000, 0,  1,  0,  12'hFFF, 0,  0,  12'h000, 0);
    tbl[12] = mkv(0, 12'h000, 0, 12'h000, 0,  0,  0,  12'h000, 1,  0,  12'hFFF, 0);

    @(negedge clk);
    do_reset();

    // Directed table: fetch stream, halt with read in flight, debug while halted.
    for (int i = 0; i < 13; i++) begin
      if_req = tbl[i].ir; if_addr = tbl[i].ia; dbg_req = tbl[i].dr;
      dbg_addr = tbl[i].da; dbg_halt = tbl[i].hlt;
      #1;
      chk1($sformatf("tbl%0d_if_gnt", i), if_gnt, tbl[i].eig);
      chk1($sformatf("tbl%0d_dbg_gnt", i), dbg_gnt, tbl[i].edg);
      chk32($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].emaddr));
      chk1($sformatf("tbl%0d_if_rvalid", i), if_rvalid, tbl[i].eiv);
      chk1($sformatf("tbl%0d_dbg_rvalid", i), dbg_rvalid, tbl[i].edv);
      chk1($sformatf("tbl%0d_halted", i), halted, tbl[i].ehalt);
      if (tbl[i].eiv) chk32($sformatf("tbl%0d_if_rdata", i), if_rdata, word(tbl[i].eraddr));
      if (tbl[i].edv) chk32($sformatf("tbl%0d_dbg_rdata", i), dbg_rdata, word(tbl[i].eraddr));
      @(negedge clk);
    end
    if_req = 1'b0; dbg_req = 1'b0; dbg_halt = 1'b0;
    @(negedge clk);

    // Contention: both requesters held; debug forced through on the ninth cycle.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if_req = 1'b1; if_addr = 12'(12'h100 + k); dbg_req = 1'b1; dbg_addr = 12'h200;
      #1;
      chk1($sformatf("cont%0d_if_gnt", k), if_gnt, k != 8);
      chk1($sformatf("cont%0d_dbg_gnt", k), dbg_gnt, k == 8);
      if (k == 9) begin
        chk1("cont9_dbg_rvalid", dbg_rvalid, 1'b1);
        chk32("cont9_dbg_rdata", dbg_rdata, word(12'h200));
      end
      @(negedge clk);
    end
    if_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);

    // Reset while a debug read is outstanding.
    do_reset();
    dbg_req = 1'b1; dbg_addr = 12'h020;
    #1;
    chk1("rstmid_dbg_gnt", dbg_gnt, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1; dbg_req = 1'b0;
    #1;
    chk1("rstmid_dbg_rvalid", dbg_rvalid, 1'b0);
    chk1("rstmid_if_rvalid", if_rvalid, 1'b0);
    @(negedge clk);
    chk1("rstmid_halted", halted, 1'b0);
    chk1("rstmid_mem_en", mem_en, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk1("rstmid_post_dbg_rvalid", dbg_rvalid, 1'b0);
    if_req = 1'b1; if_addr = 12'h030;
    #1;
    chk1("rstmid_if_gnt", if_gnt, 1'b1);
    chk32("rstmid_mem_addr", 32'(mem_addr), 32'h030);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk1("rstmid_if_rvalid2", if_rvalid, 1'b1);
    chk32("rstmid_if_rdata", if_rdata, word(12'h030));
    chk1("rstmid_dbg_rvalid2", dbg_rvalid, 1'b0);
    @(negedge clk);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else random_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
